// File: rtl/idct_pkg.sv
// Shared types, widths and bus packing helpers for the IDCT block sequencer.
package idct_pkg;

   localparam int unsigned WORD_W  = 16;
   localparam int unsigned BLOCK_N = 64;
   localparam int unsigned IDX_W   = 6;
   localparam int unsigned BUS_W   = BLOCK_N * WORD_W;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_N - 1);

   typedef logic signed [WORD_W-1:0] word_t;
   typedef word_t                    block_t [BLOCK_N];
   typedef logic [BUS_W-1:0]         bus_t;

   typedef enum logic {IN_FILL, IN_FULL}    in_state_t;
   typedef enum logic {OUT_EMPTY, OUT_DRAIN} out_state_t;

   // Flatten a block into the IDCT bus: word k lands on bits [WORD_W*k +: WORD_W].
   function automatic bus_t pack_block(input block_t blk);
      bus_t bus;
      bus = '0;
      for (int unsigned k = 0; k < BLOCK_N; k++) begin
         bus[k*WORD_W +: WORD_W] = blk[IDX_W'(k)];
      end
      return bus;
   endfunction

   // Extract word idx from the flat IDCT bus.
   function automatic word_t unpack_word(input bus_t bus, input logic [IDX_W-1:0] idx);
      return word_t'(bus[idx*WORD_W +: WORD_W]);
   endfunction

endpackage

// File: rtl/idct_latency_tracker.sv
// Follows launched blocks through the fixed-latency IDCT pipeline with a token shift register.
module idct_latency_tracker #(
   parameter int unsigned LATENCY = 29
) (
   input  logic clk,
   input  logic rst,
   input  logic launch,
   output logic capture,
   output logic inflight
);

   logic [LATENCY-1:0] token_q;

   // Shift the launch token one stage per cycle; a token launched in cycle t is at the top in cycle t+LATENCY.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         token_q <= '0;
      end else begin
         token_q <= LATENCY'({token_q, launch});
      end
   end

   assign capture  = token_q[LATENCY-1];
   assign inflight = |token_q;

endmodule

// File: rtl/idct_block_sequencer.sv
// Collects serial coefficients into a block, launches it into the IDCT, captures the results
// on the exact output cycle and replays them serially under a single-block credit.
module idct_block_sequencer
   import idct_pkg::*;
#(
   parameter int unsigned LATENCY = 29
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [WORD_W-1:0]   s_data,
   output logic [BUS_W-1:0]    idct_x,
   input  logic [BUS_W-1:0]    idct_out,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [WORD_W-1:0]   m_data,
   output logic                m_last,
   output logic                busy
);

   in_state_t          in_state_q, in_state_d;
   out_state_t         out_state_q, out_state_d;
   logic [IDX_W-1:0]   in_cnt_q, in_cnt_d;
   logic [IDX_W-1:0]   out_cnt_q, out_cnt_d;
   logic               credit_q;
   logic               in_wr;
   logic               launch;
   logic               capture;
   logic               inflight;
   logic               drain_done;
   block_t             in_buf;
   block_t             out_buf;

   idct_latency_tracker #(
      .LATENCY (LATENCY)
   ) u_tracker (
      .clk      (clk),
      .rst      (rst),
      .launch   (launch),
      .capture  (capture),
      .inflight (inflight)
   );

   // State and counter registers for both FSMs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_state_q  <= IN_FILL;
         out_state_q <= OUT_EMPTY;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
      end else begin
         in_state_q  <= in_state_d;
         out_state_q <= out_state_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
      end
   end

   // Input FSM: fill the block serially, then wait in FULL until a credit (or a same-cycle drain finish) allows launch.
   always_comb begin
      in_state_d = in_state_q;
      in_cnt_d   = in_cnt_q;
      s_ready    = 1'b0;
      in_wr      = 1'b0;
      launch     = 1'b0;
      case (in_state_q)
         IN_FILL: begin
            s_ready = 1'b1;
            if (s_valid) begin
               in_wr    = 1'b1;
               in_cnt_d = in_cnt_q + IDX_W'(1);
               if (in_cnt_q == LAST_IDX) begin
                  in_state_d = IN_FULL;
               end
            end
         end
         IN_FULL: begin
            if (credit_q || drain_done) begin
               launch     = 1'b1;
               in_state_d = IN_FILL;
            end
         end
         default: in_state_d = IN_FILL;
      endcase
   end

   // Output FSM: start draining on capture, step through out_buf on each sink handshake.
   always_comb begin
      out_state_d = out_state_q;
      out_cnt_d   = out_cnt_q;
      m_valid     = 1'b0;
      m_last      = 1'b0;
      m_data      = '0;
      drain_done  = 1'b0;
      case (out_state_q)
         OUT_EMPTY: begin
            if (capture) begin
               out_state_d = OUT_DRAIN;
               out_cnt_d   = '0;
            end
         end
         OUT_DRAIN: begin
            m_valid = 1'b1;
            m_data  = out_buf[out_cnt_q];
            m_last  = (out_cnt_q == LAST_IDX);
            if (m_ready) begin
               if (out_cnt_q == LAST_IDX) begin
                  drain_done  = 1'b1;
                  out_cnt_d   = '0;
                  out_state_d = OUT_EMPTY;
               end else begin
                  out_cnt_d = out_cnt_q + IDX_W'(1);
               end
            end
         end
         default: out_state_d = OUT_EMPTY;
      endcase
   end

   // Single credit: consumed on launch, returned when the last result is taken; both at once leaves it at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credit_q <= 1'b1;
      end else if (launch && !drain_done) begin
         credit_q <= 1'b0;
      end else if (drain_done && !launch) begin
         credit_q <= 1'b1;
      end
   end

   // Coefficient store, written at the fill index on each accepted word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < BLOCK_N; k++) begin
            in_buf[IDX_W'(k)] <= '0;
         end
      end else if (in_wr) begin
         in_buf[in_cnt_q] <= word_t'(s_data);
      end
   end

   // Result store, loaded from the IDCT outputs in the cycle the token exits the pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < BLOCK_N; k++) begin
            out_buf[IDX_W'(k)] <= '0;
         end
      end else if (capture) begin
         for (int unsigned k = 0; k < BLOCK_N; k++) begin
            out_buf[IDX_W'(k)] <= unpack_word(idct_out, IDX_W'(k));
         end
      end
   end

   // The IDCT samples its inputs only in the launch cycle, so in_buf can drive it continuously.
   always_comb begin
      idct_x = pack_block(in_buf);
   end

   // Busy whenever a block is waiting to launch, inside the pipeline, or being replayed.
   always_comb begin
      busy = (in_state_q == IN_FULL) || inflight || (out_state_q == OUT_DRAIN);
   end

endmodule

// File: tb/tb_idct_block_sequencer.sv
// Bench for idct_block_sequencer with a floating-point IDCT pipeline model and an output scoreboard.
module tb_idct_block_sequencer;

   localparam int L = 29;
   localparam int W = 16;
   localparam int N = 64;
   localparam real PI = 3.14159265358979;

   typedef logic signed [W-1:0] tw_t;
   typedef tw_t tblk_t [N];

   logic            clk = 1'b0;
   logic            rst;
   logic            s_valid;
   logic            s_ready;
   logic [W-1:0]    s_data;
   logic [N*W-1:0]  idct_x;
   logic [N*W-1:0]  idct_out;
   logic            m_valid;
   logic            m_ready;
   logic [W-1:0]    m_data;
   logic            m_last;
   logic            busy;

   int              total = 0;
   int              bad = 0;
   tw_t             exp_q [$];
   logic            sready_at_last;
   logic [N*W-1:0]  pipe [L];

   always #5 clk = ~clk;

   idct_block_sequencer #(.LATENCY(L)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .idct_x   (idct_x),
      .idct_out (idct_out),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_last   (m_last),
      .busy     (busy)
   );

   function automatic logic [N*W-1:0] pack_ref(input tblk_t b);
      logic [N*W-1:0] r;
      for (int k = 0; k < N; k++) r[k*W +: W] = b[k];
      return r;
   endfunction

   // Orthonormal 8x8 inverse DCT, row-major, rounded to nearest.
   function automatic logic [N*W-1:0] idct_ref(input logic [N*W-1:0] bus);
      real c [8][8];
      real t [8][8];
      real acc;
      tw_t w;
      logic [N*W-1:0] r;
      r = '0;
      for (int x = 0; x < 8; x++)
         for (int u = 0; u < 8; u++)
            c[x][u] = ((u == 0) ? 1.0 / $sqrt(2.0) : 1.0) * $cos(real'((2*x+1)*u) * PI / 16.0) / 2.0;
      for (int v = 0; v < 8; v++)
         for (int x = 0; x < 8; x++) begin
            acc = 0.0;
            for (int u = 0; u < 8; u++) begin
               w = bus[(v*8+u)*W +: W];
               acc = acc + c[x][u] * real'(int'(w));
            end
            t[v][x] = acc;
         end
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 8; x++) begin
            acc = 0.0;
            for (int v = 0; v < 8; v++) acc = acc + c[y][v] * t[v][x];
            r[(y*8+x)*W +: W] = W'($rtoi($floor(acc + 0.5)));
         end
      return r;
   endfunction

   // Fixed-latency IDCT with no enable: result of the inputs in cycle t appears in cycle t+L.
   always @(posedge clk) begin
      pipe[0] <= idct_ref(idct_x);
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
   end
   assign idct_out = pipe[L-1];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_expected(input tblk_t b);
      logic [N*W-1:0] r;
      r = idct_ref(pack_ref(b));
      for (int k = 0; k < N; k++) exp_q.push_back(tw_t'(r[k*W +: W]));
   endtask

   task automatic rand_block(output tblk_t b);
      for (int k = 0; k < N; k++) b[k] = tw_t'(int'($urandom_range(127)) - 64);
   endtask

   task automatic send_block(input tblk_t b, input int gap_pct);
      int i = 0;
      int cyc = 0;
      while (i < N && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (int'($urandom_range(99)) < gap_pct) begin
            s_valid = 1'b0;
         end else begin
            s_valid = 1'b1;
            s_data  = b[i];
         end
         if (s_valid && s_ready) i++;
      end
      chk("send_count", 64'(i), 64'(N));
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   task automatic drain_words(input int n, input int rdy_pct, input string tag);
      int got = 0;
      int cyc = 0;
      logic stalled = 1'b0;
      logic [W-1:0] held_d = '0;
      logic held_l = 1'b0;
      logic [W-1:0] e;
      while (got < n && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (stalled) begin
            chk({tag, "_hold_data"}, 64'(m_data), 64'(held_d));
            chk({tag, "_hold_last"}, 64'(m_last), 64'(held_l));
         end
         m_ready = (int'($urandom_range(99)) < rdy_pct);
         stalled = m_valid && !m_ready;
         held_d  = m_data;
         held_l  = m_last;
         if (m_valid && m_ready) begin
            e = (exp_q.size() > 0) ? W'(exp_q.pop_front()) : 'x;
            chk({tag, "_data"}, 64'(m_data), 64'(e));
            chk({tag, "_last"}, 64'(m_last), 64'((got % N) == N-1));
            if (m_last) sready_at_last = s_ready;
            got++;
         end
      end
      chk({tag, "_count"}, 64'(got), 64'(n));
      @(posedge clk);
      #1 m_ready = 1'b0;
   endtask

   // Called before the negedge of the cycle after a launch; checks refill starts and first result timing.
   task automatic measure_latency(input string tag);
      int n;
      @(negedge clk);
      chk({tag, "_sready_refill"}, 64'(s_ready), 64'(1));
      n = 1;
      while (!m_valid && n < 4*L) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'(L + 1));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_s_ready"}, 64'(s_ready), 64'(1));
      chk({tag, "_m_valid"}, 64'(m_valid), 64'(0));
      chk({tag, "_m_last"},  64'(m_last),  64'(0));
      chk({tag, "_m_data"},  64'(m_data),  64'(0));
      chk({tag, "_busy"},    64'(busy),    64'(0));
      total++;
      assert (idct_x === '0) else begin
         bad++;
         $error("FAIL %s_idct_x observed=%0h expected=0", tag, idct_x);
      end
   endtask

   initial begin
      tblk_t a, b1, b2, rb [8];
      logic [W-1:0] hold_d;
      logic unstable;
      logic saw_valid;

      for (int k = 0; k < L; k++) pipe[k] = '0;
      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // Known block: DC 23, first two horizontal AC terms -1, -2.
      for (int k = 0; k < N; k++) a[k] = '0;
      a[0] = 16'sd23; a[1] = -16'sd1; a[2] = -16'sd2;
      for (int k = 0; k < N; k++) exp_q.push_back((k % 8 == 0) ? 16'sd2 : 16'sd3);
      send_block(a, 0);
      @(negedge clk);
      total++;
      assert (idct_x === pack_ref(a)) else begin
         bad++;
         $error("FAIL idct_x_launch observed=%0h expected=%0h", idct_x, pack_ref(a));
      end
      chk("launch_sready", 64'(s_ready), 64'(0));
      chk("launch_busy", 64'(busy), 64'(1));
      measure_latency("t1");
      drain_words(N, 100, "t1");
      @(negedge clk);
      chk("t1_idle_busy", 64'(busy), 64'(0));

      // Back-to-back blocks: second launches on the first block's final handshake.
      rand_block(b1); rand_block(b2);
      push_expected(b1); push_expected(b2);
      sready_at_last = 1'b1;
      fork
         begin send_block(b1, 0); send_block(b2, 0); end
         drain_words(N, 100, "t2a");
      join
      chk("t2_sready_at_last", 64'(sready_at_last), 64'(0));
      measure_latency("t2");
      drain_words(N, 100, "t2b");

      // Sink stalls 100 cycles with the next block loaded; launch waits for the last handshake.
      rand_block(b1); rand_block(b2);
      push_expected(b1); push_expected(b2);
      send_block(b1, 0);
      begin
         int n = 0;
         while (!m_valid && n < 4*L) begin @(negedge clk); n++; end
         chk("t3_first_valid", 64'(m_valid), 64'(1));
      end
      send_block(b2, 0);
      @(negedge clk);
      hold_d = m_data;
      unstable = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (m_data !== hold_d || m_last !== 1'b0 || m_valid !== 1'b1 || s_ready !== 1'b0) unstable = 1'b1;
      end
      chk("t3_hold_stable", 64'(unstable), 64'(0));
      chk("t3_hold_word0", 64'(m_data), 64'(W'(exp_q[0])));
      chk("t3_busy", 64'(busy), 64'(1));
      sready_at_last = 1'b1;
      drain_words(N, 100, "t3a");
      chk("t3_sready_at_last", 64'(sready_at_last), 64'(0));
      measure_latency("t3");
      drain_words(N, 60, "t3b");

      // Eight random blocks with 50% gaps on both sides.
      for (int i = 0; i < 8; i++) begin
         rand_block(rb[i]);
         push_expected(rb[i]);
      end
      fork
         begin
            for (int i = 0; i < 8; i++) send_block(rb[i], 50);
         end
         drain_words(8*N, 50, "t4");
      join
      chk("t4_queue_empty", 64'(exp_q.size()), 64'(0));

      // Reset ten cycles after a launch discards the block.
      rand_block(b1);
      send_block(b1, 0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      rst = 1'b0;
      m_ready = 1'b1;
      saw_valid = 1'b0;
      repeat (2*L) begin
         @(negedge clk);
         if (m_valid !== 1'b0) saw_valid = 1'b1;
      end
      chk("midrst_no_valid", 64'(saw_valid), 64'(0));
      m_ready = 1'b0;
      rand_block(b2);
      push_expected(b2);
      fork
         send_block(b2, 0);
         drain_words(N, 100, "t5");
      join
      chk("t5_queue_empty", 64'(exp_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
